// File: rtl/mmc_crc16_lanes_if.sv
// mmc_crc16_lanes_if: block handshake and data bus of the multi-lane CRC16 engine.
//   master : controller / data-phase shifter side (drives start, mode, beats, abort)
//   slave  : CRC engine side (drives CRC bits, status, per-lane error flags)
// Signal names keep the engine's view: *_i flows into the engine, *_o flows out of it.
interface mmc_crc16_lanes_if #(
   parameter int unsigned LANES = 4,
   parameter int unsigned LEN_W = 12
) ();
   logic                   start_i;
   logic                   mode_i;
   logic                   wide_i;
   logic [LEN_W-1:0]       len_i;
   logic                   abort_i;
   logic                   bit_valid_i;
   logic [LANES-1:0]       bits_i;
   logic                   crc_req_o;
   logic [LANES-1:0]       crc_bits_o;
   logic                   busy_o;
   logic                   done_o;
   logic [LANES-1:0]       crc_err_o;
   logic [16*LANES-1:0]    crc_o;

   modport master (
      output start_i, mode_i, wide_i, len_i, abort_i, bit_valid_i, bits_i,
      input  crc_req_o, crc_bits_o, busy_o, done_o, crc_err_o, crc_o
   );

   modport slave (
      input  start_i, mode_i, wide_i, len_i, abort_i, bit_valid_i, bits_i,
      output crc_req_o, crc_bits_o, busy_o, done_o, crc_err_o, crc_o
   );
endinterface

// File: rtl/mmc_crc16_lanes.sv
// mmc_crc16_lanes: one CCITT CRC16 (x^16+x^12+x^5+1, init 0) per DAT lane, sequenced over
// a block. DATA accumulates len+1 beats, then CRC either shifts each lane's CRC out MSB-first
// (TX) or compares 16 received bits against it (RX), then DONE pulses for one cycle.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus_io        : mmc_crc16_lanes_if.slave (start/mode/wide/len/abort, beats, CRC, status)
//   err_cnt_o     : saturating count of failed RX blocks, present only when
//                   MMC_CRC16_ERRCNT_EN is defined
module mmc_crc16_lanes #(
   parameter int unsigned LANES = 4,
   parameter int unsigned LEN_W = 12
) (
   input  logic                clk_i,
   input  logic                rst_ni,
`ifdef MMC_CRC16_ERRCNT_EN
   output logic [7:0]          err_cnt_o,
`endif
   mmc_crc16_lanes_if.slave    bus_io
);

   typedef enum logic [1:0] {StIdle, StData, StCrc, StDone} state_e;

   state_e                  state_q, state_d;
   logic                    mode_q, mode_d;
   logic                    wide_q, wide_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic [LEN_W-1:0]        cnt_q, cnt_d;
   logic [3:0]              crc_cnt_q, crc_cnt_d;
   logic [LANES-1:0][15:0]  crc_q, crc_d;
   logic [LANES-1:0]        err_q, err_d;
   logic [LANES-1:0]        lane_en;

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      logic fb;
      fb = b ^ c[15];
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   // Lane 0 is always active; with LANES=1 there is no other lane, so wide is moot.
   always_comb begin
      lane_en = '0;
      for (int n = 0; n < LANES; n++) begin
         lane_en[n] = (n == 0) || wide_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      wide_d    = wide_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      crc_cnt_d = crc_cnt_q;
      crc_d     = crc_q;
      err_d     = err_q;
      if (bus_io.abort_i) begin
         state_d   = StIdle;
         cnt_d     = '0;
         crc_cnt_d = '0;
         crc_d     = '0;
         err_d     = '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus_io.start_i) begin
                  mode_d    = bus_io.mode_i;
                  wide_d    = bus_io.wide_i;
                  len_d     = bus_io.len_i;
                  cnt_d     = '0;
                  crc_cnt_d = '0;
                  crc_d     = '0;
                  err_d     = '0;
                  state_d   = StData;
               end
            end
            StData: begin
               if (bus_io.bit_valid_i) begin
                  for (int n = 0; n < LANES; n++) begin
                     if (lane_en[n]) crc_d[n] = crc_step(crc_q[n], bus_io.bits_i[n]);
                  end
                  // Terminal compare before incrementing, so len = all-ones never wraps.
                  if (cnt_q == len_q) begin
                     cnt_d   = '0;
                     state_d = StCrc;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            StCrc: begin
               if (bus_io.bit_valid_i) begin
                  for (int n = 0; n < LANES; n++) begin
                     if (lane_en[n]) begin
                        if (!mode_q && (bus_io.bits_i[n] != crc_q[n][15])) err_d[n] = 1'b1;
                        crc_d[n] = {crc_q[n][14:0], 1'b0};
                     end
                  end
                  if (crc_cnt_q == 4'd15) begin
                     crc_cnt_d = '0;
                     state_d   = StDone;
                  end else begin
                     crc_cnt_d = crc_cnt_q + 4'd1;
                  end
               end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         mode_q    <= 1'b0;
         wide_q    <= 1'b0;
         len_q     <= '0;
         cnt_q     <= '0;
         crc_cnt_q <= '0;
         crc_q     <= '0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         wide_q    <= wide_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         crc_cnt_q <= crc_cnt_d;
         crc_q     <= crc_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      bus_io.crc_bits_o = '0;
      for (int n = 0; n < LANES; n++) begin
         bus_io.crc_bits_o[n] = crc_q[n][15];
      end
   end

   assign bus_io.crc_o     = crc_q;
   assign bus_io.crc_err_o = err_q;
   assign bus_io.busy_o    = (state_q != StIdle);
   assign bus_io.done_o    = (state_q == StDone);
   assign bus_io.crc_req_o = (state_q == StCrc) && mode_q;

`ifdef MMC_CRC16_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((state_q == StDone) && !mode_q && (|err_q) && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) err_cnt_q <= 8'd0;
      else         err_cnt_q <= err_cnt_d;
   end

   assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_mmc_crc16_lanes.sv
// tb_mmc_crc16_lanes: directed stimulus for mmc_crc16_lanes with a block-level reference
// model (phase, beat index, per-lane CRC from the polynomial rule) checked every cycle,
// plus literal expectations for known CRC values and block latencies.
module tb_mmc_crc16_lanes;
   localparam int unsigned LANES = 4;
   localparam int unsigned LEN_W = 12;

   logic clk, rst_n;
   mmc_crc16_lanes_if #(.LANES(LANES), .LEN_W(LEN_W)) bus ();
`ifdef MMC_CRC16_ERRCNT_EN
   logic [7:0] err_cnt;
`endif

   mmc_crc16_lanes #(.LANES(LANES), .LEN_W(LEN_W)) u_dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
`ifdef MMC_CRC16_ERRCNT_EN
      .err_cnt_o (err_cnt),
`endif
      .bus_io  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // phase: 0 idle, 1 payload, 2 CRC beats, 3 done
   int               m_phase = 0;
   logic             m_mode = 1'b0, m_wide = 1'b0;
   int               m_len = 0, m_beats = 0, m_k = 0;
   logic [15:0]      m_acc [LANES];
   logic [15:0]      m_final [LANES];
   logic [LANES-1:0] m_err = '0;
   logic [16*LANES-1:0] e_crc;
   logic [LANES-1:0]    e_bits;
   logic [15:0]         v;

   function automatic logic [15:0] crc_next(input logic [15:0] c, input logic b);
      logic [15:0] s;
      s = c << 1;
      if (c[15] ^ b) s = s ^ 16'h1021;
      return s;
   endfunction

   function automatic bit active(input int l);
      return (l == 0) || m_wide;
   endfunction

   // Compare on the falling edge, then advance the model with the inputs that the next
   // rising edge will sample (stimulus changes only just after rising edges).
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_phase = 0;
            m_err   = '0;
            for (int l = 0; l < LANES; l++) begin
               m_acc[l]   = 16'h0;
               m_final[l] = 16'h0;
            end
         end else begin
            for (int l = 0; l < LANES; l++) begin
               if (m_phase == 1)      v = m_acc[l];
               else if (m_phase == 2) v = m_final[l] << m_k;
               else                   v = 16'h0;
               e_crc[16*l +: 16] = v;
               e_bits[l]         = v[15];
            end
            check("busy", bus.busy_o, m_phase != 0);
            check("done", bus.done_o, m_phase == 3);
            check("crc_req", bus.crc_req_o, (m_phase == 2) && m_mode);
            check("crc_o", bus.crc_o, e_crc);
            check("crc_bits", bus.crc_bits_o, e_bits);
            check("crc_err", bus.crc_err_o, m_err);
            if (bus.abort_i) begin
               m_phase = 0;
               m_err   = '0;
            end else begin
               case (m_phase)
                  0: if (bus.start_i) begin
                     m_mode  = bus.mode_i;
                     m_wide  = bus.wide_i;
                     m_len   = int'(bus.len_i);
                     m_beats = 0;
                     m_err   = '0;
                     for (int l = 0; l < LANES; l++) m_acc[l] = 16'h0;
                     m_phase = 1;
                  end
                  1: if (bus.bit_valid_i) begin
                     for (int l = 0; l < LANES; l++)
                        if (active(l)) m_acc[l] = crc_next(m_acc[l], bus.bits_i[l]);
                     m_beats++;
                     if (m_beats == m_len + 1) begin
                        for (int l = 0; l < LANES; l++) m_final[l] = m_acc[l];
                        m_k     = 0;
                        m_phase = 2;
                     end
                  end
                  2: if (bus.bit_valid_i) begin
                     if (!m_mode)
                        for (int l = 0; l < LANES; l++)
                           if (active(l) && (bus.bits_i[l] !== m_final[l][15-m_k]))
                              m_err[l] = 1'b1;
                     m_k++;
                     if (m_k == 16) m_phase = 3;
                  end
                  default: m_phase = 0;
               endcase
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_blk(input logic md, input logic wd, input int ln, input logic vl,
                            input logic [LANES-1:0] b);
      bus.start_i     = 1'b1;
      bus.mode_i      = md;
      bus.wide_i      = wd;
      bus.len_i       = LEN_W'(ln);
      bus.bit_valid_i = vl;
      bus.bits_i      = b;
      tick();
      bus.start_i     = 1'b0;
      bus.bit_valid_i = 1'b0;
   endtask

   task automatic beat(input logic [LANES-1:0] b);
      bus.bit_valid_i = 1'b1;
      bus.bits_i      = b;
      tick();
      bus.bit_valid_i = 1'b0;
   endtask

   logic [LANES-1:0] pat [8] = '{4'h1, 4'hA, 4'h3, 4'hF, 4'h0, 4'h6, 4'hC, 4'h9};
   logic [LANES-1:0] rec [2][16];
   int               rcnt [2];

   task automatic run_tx(input int run, input bit gap, output int c, output int gaps);
      int idx;
      bit vb;
      idx = 0;
      gaps = 0;
      rcnt[run] = 0;
      start_blk(1'b1, 1'b1, 7, 1'b0, '0);
      if (gap) bus.len_i = LEN_W'(2);  // must not affect the running block
      c = 1;
      while (!bus.done_o && c < 200) begin
         vb = !gap || (c % 2 == 1);
         if (vb && bus.crc_req_o && rcnt[run] < 16) begin
            rec[run][rcnt[run]] = bus.crc_bits_o;
            rcnt[run]++;
         end
         bus.bit_valid_i = vb;
         bus.bits_i      = (idx < 8) ? pat[idx] : '0;
         bus.start_i     = gap && (c == 5);  // ignored while busy
         if (vb) idx++;
         else    gaps++;
         tick();
         c++;
      end
      bus.bit_valid_i = 1'b0;
      bus.start_i     = 1'b0;
      check("run_tx_done_seen", bus.done_o, 1'b1);
   endtask

`ifdef MMC_CRC16_ERRCNT_EN
   // len=0, single zero data beat leaves CRC 0; feeding ones on lane 0 fails the block.
   task automatic rx_small(input bit fail);
      start_blk(1'b0, 1'b0, 0, 1'b0, '0);
      beat('0);
      for (int k = 0; k < 16; k++) beat(fail ? 4'h1 : 4'h0);
      tick();
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, expected $finish");
      $fatal(1);
   end

   int c, c0, c1, gaps, req, dcnt;
   logic [15:0] lit;
   logic [LANES-1:0] b;

   initial begin
      rst_n = 1'b0;
      bus.start_i = 1'b0; bus.mode_i = 1'b0; bus.wide_i = 1'b0; bus.len_i = '0;
      bus.abort_i = 1'b0; bus.bit_valid_i = 1'b0; bus.bits_i = '0;
      tick();
      check("rst_busy", bus.busy_o, 1'b0);
      check("rst_done", bus.done_o, 1'b0);
      check("rst_crc_req", bus.crc_req_o, 1'b0);
      check("rst_crc_bits", bus.crc_bits_o, '0);
      check("rst_crc_o", bus.crc_o, '0);
      check("rst_crc_err", bus.crc_err_o, '0);
`ifdef MMC_CRC16_ERRCNT_EN
      check("rst_err_cnt", err_cnt, 8'd0);
`endif
      tick();
      rst_n = 1'b1;
      tick();

      // T1: RX narrow, 4096 ones (the beat in the start cycle must be ignored)
      start_blk(1'b0, 1'b0, 4095, 1'b1, '1);
      check("t1_busy_after_start", bus.busy_o, 1'b1);
      for (int i = 0; i < 4096; i++) beat('1);
      check("t1_crc_lane0", bus.crc_o[15:0], 16'h7FA1);
      check("t1_inactive_lanes", bus.crc_o[63:16], '0);
      lit = 16'h7FA1;
      for (int k = 0; k < 16; k++) begin
         b = LANES'($urandom);
         b[0] = lit[15-k];
         beat(b);
      end
      check("t1_done", bus.done_o, 1'b1);
      check("t1_err", bus.crc_err_o, '0);
      tick();
      check("t1_done_one_cycle", bus.done_o, 1'b0);

      // T2: TX narrow, all-zero payload; latency len+1+16+1 from the start cycle
      start_blk(1'b1, 1'b0, 4095, 1'b0, '0);
      bus.bit_valid_i = 1'b1;
      bus.bits_i = '0;
      c = 1;
      req = 0;
      while (!bus.done_o && c < 6000) begin
         if (bus.crc_req_o) req++;
         tick();
         c++;
      end
      bus.bit_valid_i = 1'b0;
      check("t2_latency", c, 4113);
      check("t2_req_beats", req, 16);
      tick();

      // T3: RX wide, 1024 ones per lane, lane 2 last CRC bit flipped
      start_blk(1'b0, 1'b1, 1023, 1'b0, '0);
      for (int i = 0; i < 1024; i++) beat('1);
      for (int l = 1; l < LANES; l++)
         check("t3_lanes_equal", bus.crc_o[16*l +: 16], bus.crc_o[15:0]);
      for (int k = 0; k < 16; k++) begin
         for (int l = 0; l < LANES; l++) b[l] = m_final[l][15-k] ^ ((l == 2) && (k == 15));
         beat(b);
      end
      check("t3_done", bus.done_o, 1'b1);
      check("t3_err", bus.crc_err_o, 4'b0100);
      tick();
      tick();
      check("t3_err_held", bus.crc_err_o, 4'b0100);

      // T4: TX wide with 1-0-1 valid gaps vs gap-free run
      run_tx(0, 1'b0, c0, gaps);
      check("t4_nogap_latency", c0, 25);
      tick();
      run_tx(1, 1'b1, c1, gaps);
      check("t4_gap_latency", c1, 25 + gaps);
      check("t4_beats_a", rcnt[0], 16);
      check("t4_beats_b", rcnt[1], 16);
      for (int r = 0; r < 16; r++) check("t4_crc_seq", rec[1][r], rec[0][r]);
      tick();

      // T5: abort together with start mid-DATA, then a normal RX block
      start_blk(1'b1, 1'b1, 100, 1'b0, '0);
      for (int i = 0; i < 10; i++) beat(4'h5);
      bus.abort_i = 1'b1;
      bus.start_i = 1'b1;
      bus.bit_valid_i = 1'b1;
      tick();
      bus.abort_i = 1'b0;
      bus.start_i = 1'b0;
      bus.bit_valid_i = 1'b0;
      check("t5_idle", bus.busy_o, 1'b0);
      check("t5_crc_cleared", bus.crc_o, '0);
      dcnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.done_o || bus.busy_o) dcnt++;
         tick();
      end
      check("t5_no_done", dcnt, 0);
      start_blk(1'b0, 1'b0, 1, 1'b0, '0);
      beat(4'h1);
      beat(4'h1);
      check("t5_crc_11", bus.crc_o[15:0], 16'h3063);
      lit = 16'h3063;
      for (int k = 0; k < 16; k++) beat({3'b000, lit[15-k]});
      check("t5_done", bus.done_o, 1'b1);
      check("t5_err", bus.crc_err_o, '0);
      tick();

`ifdef MMC_CRC16_ERRCNT_EN
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("cnt_after_reset", err_cnt, 8'd0);
      rx_small(1'b1);
      rx_small(1'b1);
      rx_small(1'b0);
      rx_small(1'b1);
      check("cnt_three", err_cnt, 8'd3);
      for (int i = 0; i < 300; i++) rx_small(1'b1);
      check("cnt_saturate", err_cnt, 8'd255);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mmc_crc16_lanes.md
# mmc_crc16_lanes

Multi-lane CRC16 engine for the MMC/SD data path: one CCITT CRC16 (x^16+x^12+x^5+1, init 0) per DAT lane, sequenced over a whole data block. It counts the payload beats, then either emits each lane's 16-bit CRC MSB-first (TX/write) or compares the 16 received CRC bits against the computed value (RX/read). It sits between the data-phase shifter and the DAT pad logic, and gives the controller a single start/done handshake per block with per-lane error flags.

## Interface
- LANES, 4, number of DAT lanes instantiated (legal: 1, 4, 8)
- LEN_W, 12, width of the block-length field (beats per lane minus 1)

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  begin a block; sampled only in IDLE
- mode_i  in  1  latched at start: 1 = TX generate, 0 = RX check
- wide_i  in  1  latched at start: 0 = lane 0 only, 1 = all LANES lanes
- len_i  in  LEN_W  latched at start: payload beats per lane minus 1
- abort_i  in  1  return to IDLE immediately; has priority over all other inputs
- bit_valid_i  in  1  one beat present on bits_i (data or received CRC)
- bits_i  in  LANES  one bit per lane; bit n = DAT[n]
- crc_req_o  out  1  TX CRC phase: crc_bits_o is valid and is consumed on bit_valid_i
- crc_bits_o  out  LANES  current CRC MSB per lane (crc[15])
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse at block end (not raised on abort)
- crc_err_o  out  LANES  RX per-lane mismatch; held until next accepted start
- crc_o  out  16*LANES  live CRC registers; lane n occupies bits [16n+15:16n]

## Operation
- States: IDLE, DATA, CRC, DONE.
- IDLE: start_i=1 latches mode/wide/len, clears all CRC registers, the beat counter and crc_err_o, then enters DATA.
- DATA: each bit_valid_i updates every active lane with the serial step: fb = bit ^ crc[15]; crc = {crc[14:0],0} ^ (fb ? 16'h1021 : 0). The beat counter increments. On the beat where count == len, the state moves to CRC and the counter is cleared.
- CRC, TX: crc_req_o=1. On each bit_valid_i (bits_i ignored), each lane shifts left by one with zero fill, so the next MSB is presented on the following cycle.
- CRC, RX: on each bit_valid_i, bits_i[n] is compared with crc[15] of lane n. A mismatch sets the sticky err[n]. Each lane then shifts left by one with zero fill.
- After the 16th CRC beat the state moves to DONE. DONE lasts one cycle with done_o=1, then returns to IDLE.
- Inactive lanes (wide=0, lanes 1..LANES-1) hold 0 in crc_o, crc_bits_o and crc_err_o.
- LANES=1 ignores wide_i.
- TX mode never sets crc_err_o.
- abort_i: next state is IDLE, and the CRC registers and counter are cleared. crc_err_o is cleared and done_o is not pulsed.
- start_i in any state other than IDLE is ignored.
- len_i is captured once at start, so later changes have no effect on the running block.

## Timing
- Reset values: crc_o=0, crc_bits_o=0, crc_req_o=0, busy_o=0, done_o=0, crc_err_o=0, state IDLE.
- busy_o rises the cycle after start_i.
- crc_o reflects a beat one cycle after that beat is sampled.
- bit_valid_i may gap arbitrarily. No update happens without it.
- A beat in the same cycle as start_i is ignored.
- Latency: with bit_valid_i held high, done_o fires len+1+16+1 cycles after the start cycle.
- After the last data beat, crc_req_o (TX) and crc_bits_o = final payload CRC MSB appear on the next cycle.
- crc_err_o is valid no later than the done_o cycle.
- abort_i and start_i in the same cycle: the abort wins and start is dropped.
- Counter at len = 2^LEN_W-1: the terminal compare must be taken before the counter wraps.

## Configuration
- MMC_CRC16_ERRCNT_EN defined:
  - adds output err_cnt_o [7:0], reset 0.
  - increments on each RX done_o with any crc_err_o bit set.
  - saturates at 255.
  - cleared only by reset.
- Undefined: no counter logic and no err_cnt_o port.

## Test plan
- RX, wide=0, len=4095, 4096 ones on lane 0 -> crc_o[15:0]=16'h7FA1 at CRC entry. Feeding 7FA1 MSB-first -> done_o pulses and crc_err_o=0.
- TX, wide=0, len=4095, all-zero data -> crc_bits_o=0 for all 16 beats and crc_req_o high for exactly 16 beats. done_o follows the cycle after the 16th beat.
- RX, LANES=4, wide=1, len=1023, all ones on every lane, CRC lane 2 with bit 0 flipped -> crc_err_o=4'b0100. All four crc_o fields are equal at CRC entry.
- bit_valid_i toggled 1-0-1 through a TX block -> output matches the gap-free run, and done_o is delayed by exactly the number of gap cycles.
- abort_i asserted mid-DATA together with start_i -> IDLE next cycle, crc_o=0, no done_o. A following start runs normally.
- With MMC_CRC16_ERRCNT_EN defined: 3 failing RX blocks and 1 passing -> err_cnt_o=3. 300 failing blocks -> err_cnt_o=255.
